// File: rtl/conv_inst_pack.sv
// rtl/conv_inst_pack.sv - packs IN single conv instructions into one bundle for the loop stage (optional flush: CONV_INST_PACK_FLUSH_EN)
module conv_inst_pack #(
   parameter int IRW = 30,
   parameter int IN  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IRW-1:0]    m_inst,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic              m_last,
   output logic [IRW*IN-1:0] s_inst,
   output logic              s_valid,
   input  logic              s_ready,
   output logic              idle
);

   localparam int             SW        = (IN > 1) ? $clog2(IN) : 1;
   localparam logic [SW-1:0]  LAST_SLOT = SW'(IN - 1);

   logic [SW-1:0]         r_slot;
   logic [IRW*(IN-1)-1:0] r_pack;
   logic [IRW*IN-1:0]     r_s_inst;
   logic                  r_s_valid;

   logic                  w_last_eff;
   logic                  w_complete_beat;
   logic                  w_accept;
   logic [IRW*IN-1:0]     w_bundle;

`ifdef CONV_INST_PACK_FLUSH_EN
   assign w_last_eff = m_last;
`else
   // m_last stays on the port but has no effect when flush is compiled out
   logic w_unused_last;
   assign w_unused_last = m_last;
   assign w_last_eff    = 1'b0;
`endif

   // A beat completes the bundle when it fills the top slot or closes it early
   assign w_complete_beat = (r_slot == LAST_SLOT) || w_last_eff;

   // Non-completing beats always fit; a completing beat needs the output register free or draining
   assign m_ready  = ~w_complete_beat | ~r_s_valid | s_ready;
   assign w_accept = m_valid & m_ready;

   // Assemble the outgoing bundle: held slots below r_slot, current beat at r_slot, zero padding above
   always_comb begin
      w_bundle = '0;
      for (int k = 0; k < IN - 1; k++) begin
         if (SW'(k) < r_slot) begin
            w_bundle[IRW*k +: IRW] = r_pack[IRW*k +: IRW];
         end
      end
      for (int k = 0; k < IN; k++) begin
         if (SW'(k) == r_slot) begin
            w_bundle[IRW*k +: IRW] = m_inst;
         end
      end
   end

   // Slot/pack bookkeeping and the output register with swap-on-drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot    <= '0;
         r_pack    <= '0;
         r_s_inst  <= '0;
         r_s_valid <= 1'b0;
      end else if (w_accept && w_complete_beat) begin
         r_s_inst  <= w_bundle;
         r_s_valid <= 1'b1;
         r_slot    <= '0;
         r_pack    <= '0;
      end else begin
         if (w_accept) begin
            for (int k = 0; k < IN - 1; k++) begin
               if (SW'(k) == r_slot) begin
                  r_pack[IRW*k +: IRW] <= m_inst;
               end
            end
            r_slot <= r_slot + SW'(1);
         end
         if (r_s_valid && s_ready) begin
            r_s_valid <= 1'b0;
         end
      end
   end

   assign s_inst  = r_s_inst;
   assign s_valid = r_s_valid;
   assign idle    = (r_slot == '0) && ~r_s_valid;

endmodule

// File: tb/tb_conv_inst_pack.sv
// tb/tb_conv_inst_pack.sv - self-checking bench for conv_inst_pack (honours CONV_INST_PACK_FLUSH_EN)
module tb_conv_inst_pack;

   localparam int IRW = 30;
   localparam int IN  = 3;
   localparam int BW  = IRW * IN;
`ifdef CONV_INST_PACK_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [IRW-1:0] m_inst = '0;
   logic           m_valid = 1'b0;
   logic           m_ready;
   logic           m_last = 1'b0;
   logic [BW-1:0]  s_inst;
   logic           s_valid;
   logic           s_ready = 1'b0;
   logic           idle;

   int n_pass  = 0;
   int n_total = 0;

   conv_inst_pack #(.IRW(IRW), .IN(IN)) dut (
      .clk     (clk),
      .rst     (rst),
      .m_inst  (m_inst),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_last  (m_last),
      .s_inst  (s_inst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .idle    (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
   endtask

   // Reference model: list of instructions accepted so far for the open bundle, plus the presented bundle
   logic [IRW-1:0] q [IN];
   int             cnt  = 0;
   logic           mv   = 1'b0;
   logic [BW-1:0]  mi   = '0;
   bit             live = 1'b0;

   function automatic bit would_complete();
      return (cnt == IN - 1) || (FLUSH && m_last);
   endfunction

   function automatic bit exp_m_ready();
      return !would_complete() || !mv || s_ready;
   endfunction

   always @(posedge clk) begin
      bit acc, comp, drain;
      if (rst) begin
         cnt = 0; mv = 1'b0; mi = '0; live = 1'b1;
      end else if (live) begin
         comp  = would_complete();
         acc   = m_valid && exp_m_ready();
         drain = mv && s_ready;
         if (acc) begin
            q[cnt] = m_inst;
            cnt++;
         end
         if (acc && comp) begin
            mi = '0;
            for (int k = 0; k < cnt; k++) mi[IRW*k +: IRW] = q[k];
            mv  = 1'b1;
            cnt = 0;
         end else if (drain) begin
            mv = 1'b0;
         end
      end
   end

   // Every cycle, away from the active edge, the DUT must agree with the model
   always @(negedge clk) begin
      if (live) begin
         chk("m_ready", BW'(m_ready), BW'(exp_m_ready()));
         chk("s_valid", BW'(s_valid), BW'(mv));
         chk("s_inst",  s_inst, mi);
         chk("idle",    BW'(idle), BW'((cnt == 0) && !mv));
      end
   end

   task automatic drive(input bit v, input logic [IRW-1:0] inst, input bit last, input bit sr);
      m_valid = v; m_inst = inst; m_last = last; s_ready = sr;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_valid", BW'(s_valid), '0);
      chk("rst_s_inst",  s_inst, '0);
      chk("rst_idle",    BW'(idle), BW'(1));
      chk("rst_m_ready", BW'(m_ready), BW'(1));
      rst = 1'b0;

      // Two full bundles with the loop stage always ready
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, IRW'(i), 1'b0, 1'b1);
         if (i == 3) begin
            chk("b1_valid", BW'(s_valid), BW'(1));
            chk("b1_inst",  s_inst, {30'h3, 30'h2, 30'h1});
         end
         if (i == 4) chk("b1_pulse", BW'(s_valid), '0);
         if (i == 6) chk("b2_inst", s_inst, {30'h6, 30'h5, 30'h4});
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      chk("b2_pulse", BW'(s_valid), '0);
      chk("end_idle", BW'(idle), BW'(1));

      // Stalled output: bundle holds while more beats pack behind it
      for (int i = 0; i < 5; i++) drive(1'b1, IRW'(32'hA + i), 1'b0, 1'b0);
      chk("stall_inst", s_inst, {30'hC, 30'hB, 30'hA});
      m_valid = 1'b1; m_inst = 30'hF; m_last = 1'b0; s_ready = 1'b0;
      repeat (3) begin
         #1;
         chk("stall_m_ready", BW'(m_ready), '0);
         chk("stall_hold",    s_inst, {30'hC, 30'hB, 30'hA});
         @(posedge clk); #1;
      end
      s_ready = 1'b1;
      #1;
      chk("unstall_m_ready", BW'(m_ready), BW'(1));
      @(posedge clk); #1;
      chk("swap_valid", BW'(s_valid), BW'(1));
      chk("swap_inst",  s_inst, {30'hF, 30'hE, 30'hD});

      // Back-to-back random beats with the loop stage ready
      for (int i = 0; i < 9; i++) drive(1'b1, IRW'($urandom), 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b1);

`ifdef CONV_INST_PACK_FLUSH_EN
      drive(1'b1, 30'h7, 1'b0, 1'b1);
      drive(1'b1, 30'h8, 1'b1, 1'b1);
      chk("flush2_inst", s_inst, {30'h0, 30'h8, 30'h7});
      drive(1'b1, 30'h9, 1'b1, 1'b1);
      chk("flush1_inst", s_inst, {30'h0, 30'h0, 30'h9});
      drive(1'b0, '0, 1'b1, 1'b1);
      chk("flush_idle", BW'(idle), BW'(1));
`else
      drive(1'b1, 30'h7, 1'b0, 1'b1);
      drive(1'b1, 30'h8, 1'b1, 1'b1);
      chk("noflush_no_bundle", BW'(s_valid), '0);
      drive(1'b1, 30'h5, 1'b0, 1'b1);
      chk("noflush_inst", s_inst, {30'h5, 30'h8, 30'h7});
      drive(1'b0, '0, 1'b0, 1'b1);
`endif

      // Reset mid-bundle with a stalled output
      for (int i = 0; i < 5; i++) drive(1'b1, IRW'(32'h21 + i), 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("mid_rst_valid", BW'(s_valid), '0);
      chk("mid_rst_idle",  BW'(idle), BW'(1));
      for (int i = 0; i < 3; i++) drive(1'b1, IRW'(32'h31 + i), 1'b0, 1'b1);
      chk("post_rst_inst", s_inst, {30'h33, 30'h32, 30'h31});

      // Randomized traffic, including flush marks and occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 3) != 0, IRW'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) != 0);
      end
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
